// File: rtl/cnn_header_reader.sv
// cnn_header_reader: walks the CNN parameter header in the shared byte RAM,
// latches the global fields and emits one descriptor per layer. The running
// filter-block address is accumulated layer by layer and finally compared
// with the stored dense-section offset as a consistency check.
//
// Descriptor handshake: a descriptor is transferred on a rising edge where
// desc_valid and desc_ready are both high; once desc_valid rises it stays
// high and every descriptor field stays constant until that transfer.
module cnn_header_reader #(
    parameter int          MAX_LAYERS = 10,
    parameter logic [15:0] HDR_BASE   = 16'd0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    output logic [15:0] ramAddress,
    output logic        readSignal,
    input  logic [7:0]  ramDataOut,
    output logic [7:0]  filterSize,
    output logic [7:0]  numLayers,
    output logic [15:0] filterOffset,
    output logic [15:0] denseOffset,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [7:0]  layerIdx,
    output logic [7:0]  layerFilters,
    output logic [7:0]  layerType,
    output logic [7:0]  layerDense,
    output logic [15:0] layerBase,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [3:0]  dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HDR     = 4'd1,
        S_CHECK   = 4'd2,
        S_F_CNT   = 4'd3,
        S_F_TYPE  = 4'd4,
        S_F_DENSE = 4'd5,
        S_CALC    = 4'd6,
        S_PRESENT = 4'd7,
        S_FINAL   = 4'd8
    } state_t;

    localparam logic [7:0] MAX_L8 = 8'(MAX_LAYERS);

    state_t      state_q;
    logic        phase_q;      // 0: issue cycle, 1: capture cycle
    logic [2:0]  hdr_cnt_q;
    logic [7:0]  layer_q;
    logic [15:0] base_q;

    logic [15:0] ramAddress_q;
    logic        readSignal_q;
    logic [7:0]  filterSize_q;
    logic [7:0]  numLayers_q;
    logic [15:0] filterOffset_q;
    logic [15:0] denseOffset_q;
    logic        desc_valid_q;
    logic [7:0]  layerIdx_q;
    logic [7:0]  layerFilters_q;
    logic [7:0]  layerType_q;
    logic [7:0]  layerDense_q;
    logic [15:0] layerBase_q;
    logic        busy_q;
    logic        done_q;
    logic [1:0]  err_q;

    // Address and arithmetic helpers derived from the current layer.
    logic [15:0] hdr_addr_d;
    logic [15:0] cnt_addr_d;
    logic [15:0] type_addr_d;
    logic [15:0] dense_addr_d;
    logic        is_last_d;
    logic [15:0] fs_sq_d;
    logic [23:0] fs_term_d;
    logic [23:0] incr_d;
    logic [24:0] base_sum_d;

    // Per-layer byte addresses and the filter-block size of the current layer
    always_comb begin
        hdr_addr_d   = HDR_BASE + {13'd0, hdr_cnt_q} + 16'd1;
        cnt_addr_d   = HDR_BASE + 16'd6 + {8'd0, layer_q};
        type_addr_d  = cnt_addr_d + {8'd0, numLayers_q};
        dense_addr_d = type_addr_d + {8'd0, numLayers_q};
        is_last_d    = (layer_q == (numLayers_q - 8'd1));
        fs_sq_d      = {8'd0, filterSize_q} * {8'd0, filterSize_q};
        fs_term_d    = {8'd0, fs_sq_d} + 24'd1;
        incr_d       = {16'd0, layerFilters_q} * fs_term_d;
        base_sum_d   = {9'd0, base_q} + {1'b0, incr_d};
    end

    // Parse sequencer with registered RAM strobes, descriptors and status
    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q        <= S_IDLE;
            phase_q        <= 1'b0;
            hdr_cnt_q      <= 3'd0;
            layer_q        <= 8'd0;
            base_q         <= 16'd0;
            ramAddress_q   <= 16'd0;
            readSignal_q   <= 1'b0;
            filterSize_q   <= 8'd0;
            numLayers_q    <= 8'd0;
            filterOffset_q <= 16'd0;
            denseOffset_q  <= 16'd0;
            desc_valid_q   <= 1'b0;
            layerIdx_q     <= 8'd0;
            layerFilters_q <= 8'd0;
            layerType_q    <= 8'd0;
            layerDense_q   <= 8'd0;
            layerBase_q    <= 16'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 2'd0;
        end else begin
            // Strobes are single-cycle unless a state re-issues them.
            readSignal_q <= 1'b0;
            ramAddress_q <= 16'd0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_HDR;
                        busy_q       <= 1'b1;
                        err_q        <= 2'd0;
                        layer_q      <= 8'd0;
                        hdr_cnt_q    <= 3'd0;
                        phase_q      <= 1'b0;
                        readSignal_q <= 1'b1;
                        ramAddress_q <= HDR_BASE;
                    end
                end
                S_HDR: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        case (hdr_cnt_q)
                            3'd0:    filterSize_q         <= ramDataOut;
                            3'd1:    numLayers_q          <= ramDataOut;
                            3'd2:    filterOffset_q[15:8] <= ramDataOut;
                            3'd3:    filterOffset_q[7:0]  <= ramDataOut;
                            3'd4:    denseOffset_q[15:8]  <= ramDataOut;
                            default: denseOffset_q[7:0]   <= ramDataOut;
                        endcase
                        phase_q <= 1'b0;
                        if (hdr_cnt_q == 3'd5) begin
                            state_q <= S_CHECK;
                        end else begin
                            hdr_cnt_q    <= hdr_cnt_q + 3'd1;
                            readSignal_q <= 1'b1;
                            ramAddress_q <= hdr_addr_d;
                        end
                    end
                end
                S_CHECK: begin
                    if ((numLayers_q == 8'd0) || (numLayers_q > MAX_L8)) begin
                        err_q   <= 2'd1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FINAL;
                    end else begin
                        base_q       <= filterOffset_q;
                        phase_q      <= 1'b0;
                        state_q      <= S_F_CNT;
                        readSignal_q <= 1'b1;
                        ramAddress_q <= cnt_addr_d;
                    end
                end
                S_F_CNT: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        layerFilters_q <= ramDataOut;
                        phase_q        <= 1'b0;
                        state_q        <= S_F_TYPE;
                        readSignal_q   <= 1'b1;
                        ramAddress_q   <= type_addr_d;
                    end
                end
                S_F_TYPE: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        layerType_q <= ramDataOut;
                        phase_q     <= 1'b0;
                        if (is_last_d) begin
                            // The last layer has no dense-count byte.
                            layerDense_q <= 8'd0;
                            state_q      <= S_CALC;
                        end else begin
                            state_q      <= S_F_DENSE;
                            readSignal_q <= 1'b1;
                            ramAddress_q <= dense_addr_d;
                        end
                    end
                end
                S_F_DENSE: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        layerDense_q <= ramDataOut;
                        phase_q      <= 1'b0;
                        state_q      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (base_sum_d[24:16] != 9'd0) begin
                        err_q   <= 2'd3;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FINAL;
                    end else begin
                        layerBase_q  <= base_q;
                        layerIdx_q   <= layer_q;
                        base_q       <= base_sum_d[15:0];
                        desc_valid_q <= 1'b1;
                        state_q      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (desc_ready) begin
                        desc_valid_q <= 1'b0;
                        layer_q      <= layer_q + 8'd1;
                        if (is_last_d) begin
                            // base_q already holds the end of the last block.
                            if (base_q != denseOffset_q) begin
                                err_q <= 2'd2;
                            end
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_FINAL;
                        end else begin
                            phase_q      <= 1'b0;
                            state_q      <= S_F_CNT;
                            readSignal_q <= 1'b1;
                            ramAddress_q <= cnt_addr_d + 16'd1;
                        end
                    end
                end
                S_FINAL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ramAddress   = ramAddress_q;
    assign readSignal   = readSignal_q;
    assign filterSize   = filterSize_q;
    assign numLayers    = numLayers_q;
    assign filterOffset = filterOffset_q;
    assign denseOffset  = denseOffset_q;
    assign desc_valid   = desc_valid_q;
    assign layerIdx     = layerIdx_q;
    assign layerFilters = layerFilters_q;
    assign layerType    = layerType_q;
    assign layerDense   = layerDense_q;
    assign layerBase    = layerBase_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cnn_header_reader.sv
// Directed bench for cnn_header_reader: a byte RAM model answers reads one
// cycle after the strobe, and each scenario checks descriptors, done timing
// and the error code against hand-computed values.
module tb_cnn_header_reader;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] ramAddress;
    logic        readSignal;
    logic [7:0]  ramDataOut;
    logic [7:0]  filterSize;
    logic [7:0]  numLayers;
    logic [15:0] filterOffset;
    logic [15:0] denseOffset;
    logic        desc_valid;
    logic        desc_ready;
    logic [7:0]  layerIdx;
    logic [7:0]  layerFilters;
    logic [7:0]  layerType;
    logic [7:0]  layerDense;
    logic [15:0] layerBase;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [3:0]  dbg_state;

    // Clock
    always #5 clk = ~clk;

    cnn_header_reader #(.MAX_LAYERS(10), .HDR_BASE(16'd0)) dut (
        .clk          (clk),
        .RST          (RST),
        .start        (start),
        .ramAddress   (ramAddress),
        .readSignal   (readSignal),
        .ramDataOut   (ramDataOut),
        .filterSize   (filterSize),
        .numLayers    (numLayers),
        .filterOffset (filterOffset),
        .denseOffset  (denseOffset),
        .desc_valid   (desc_valid),
        .desc_ready   (desc_ready),
        .layerIdx     (layerIdx),
        .layerFilters (layerFilters),
        .layerType    (layerType),
        .layerDense   (layerDense),
        .layerBase    (layerBase),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .dbg_state_o  (dbg_state)
    );

    // Byte RAM: data follows the strobe by one cycle; junk otherwise.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (readSignal) ramDataOut <= mem[ramAddress[7:0]];
        else            ramDataOut <= 8'($urandom_range(0, 255));
    end

    int checks   = 0;
    int failures = 0;

    // Descriptor = {idx, filters, type, dense, base}
    logic [47:0] desc_log[$];
    int          done_cyc;
    logic [1:0]  err_at_done;
    int          first_valid;
    logic        stable_ok;
    logic        rd_log   [0:63];
    logic [15:0] addr_log [0:63];
    logic        busy_log [0:63];

    localparam logic [47:0] E0 = 48'h00_06_00_0C_000E;
    localparam logic [47:0] E1 = 48'h01_06_01_0C_001A;
    localparam logic [47:0] E2 = 48'h02_06_01_00_0026;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] log_at(input int i);
        if (desc_log.size() > i) return desc_log[i];
        return '1;
    endfunction

    task automatic load_hdr(input logic [7:0] fs, input logic [7:0] nl,
                            input logic [15:0] fo, input logic [15:0] dof);
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mem[0] = fs;
        mem[1] = nl;
        mem[2] = fo[15:8];
        mem[3] = fo[7:0];
        mem[4] = dof[15:8];
        mem[5] = dof[7:0];
    endtask

    task automatic load_nominal(input logic [15:0] dof);
        load_hdr(8'd1, 8'd3, 16'd14, dof);
        mem[6]  = 8'd6;
        mem[7]  = 8'd6;
        mem[8]  = 8'd6;
        mem[9]  = 8'd0;
        mem[10] = 8'd1;
        mem[11] = 8'd1;
        mem[12] = 8'd12;
        mem[13] = 8'd12;
    endtask

    // Pulses start and follows the parse cycle by cycle (cycle 1 is the one
    // after the accepting edge). Every descriptor seen with ready high is
    // logged once; a stall holds ready low for stall_cycles on stall_layer.
    task automatic run_parse(input int stall_layer, input int stall_cycles, input int rst_at);
        int          stalled;
        logic [47:0] snap;
        logic [47:0] cur;
        desc_log.delete();
        done_cyc    = -1;
        err_at_done = 2'd0;
        first_valid = -1;
        stable_ok   = 1'b1;
        stalled     = 0;
        snap        = '0;
        desc_ready  = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc < 64) begin
                rd_log[cyc]   = readSignal;
                addr_log[cyc] = ramAddress;
                busy_log[cyc] = busy;
            end
            if (cyc == rst_at) begin
                RST = 1'b0;
                break;
            end
            // A stray start mid-parse must be ignored.
            start = (cyc == 5 && stall_cycles > 0);
            if (desc_valid) begin
                cur = {layerIdx, layerFilters, layerType, layerDense, layerBase};
                if (first_valid < 0) first_valid = cyc;
                if (stalled > 0 && layerIdx == 8'(stall_layer) && cur !== snap) stable_ok = 1'b0;
                if (layerIdx == 8'(stall_layer) && stalled < stall_cycles) begin
                    if (stalled == 0) snap = cur;
                    desc_ready = 1'b0;
                    stalled++;
                end else begin
                    desc_ready = 1'b1;
                    desc_log.push_back(cur);
                end
            end else begin
                desc_ready = 1'b1;
            end
            if (done) begin
                done_cyc    = cyc;
                err_at_done = err;
                break;
            end
            @(negedge clk);
        end
        start      = 1'b0;
        desc_ready = 1'b1;
    endtask

    initial begin
        // Reset
        RST        = 1'b0;
        start      = 1'b0;
        desc_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        check("rst_read",   48'({readSignal, ramAddress}), 48'd0);
        check("rst_glob",   48'({filterSize, numLayers, filterOffset, denseOffset}), 48'd0);
        check("rst_desc",   {layerIdx, layerFilters, layerType, layerDense, layerBase}, 48'd0);
        check("rst_status", 48'({desc_valid, busy, done, err}), 48'd0);
        check("rst_state",  48'(dbg_state), 48'd0);

        // Nominal header, ready tied high
        load_nominal(16'd50);
        run_parse(-1, 0, 0);
        check("nom_busy_c1",  48'(busy_log[1]), 48'd1);
        check("nom_rd_c1",    48'({rd_log[1], addr_log[1]}), 48'h1_0000);
        check("nom_rd_c2",    48'({rd_log[2], addr_log[2]}), 48'h0_0000);
        check("nom_rd_c3",    48'({rd_log[3], addr_log[3]}), 48'h1_0001);
        check("nom_rd_cnt0",  48'({rd_log[14], addr_log[14]}), 48'h1_0006);
        check("nom_rd_typ0",  48'({rd_log[16], addr_log[16]}), 48'h1_0009);
        check("nom_rd_dns0",  48'({rd_log[18], addr_log[18]}), 48'h1_000C);
        check("nom_rd_typ2",  48'({rd_log[32], addr_log[32]}), 48'h1_000B);
        check("nom_no_dns2",  48'({rd_log[34], addr_log[34]}), 48'h0_0000);
        check("nom_first_v",  48'(first_valid), 48'd21);
        check("nom_ndesc",    48'(desc_log.size()), 48'd3);
        check("nom_desc0",    log_at(0), E0);
        check("nom_desc1",    log_at(1), E1);
        check("nom_desc2",    log_at(2), E2);
        check("nom_done_cyc", 48'(done_cyc), 48'd36);
        check("nom_err",      48'(err_at_done), 48'd0);
        @(negedge clk);
        check("nom_done_pulse", 48'({done, busy, desc_valid}), 48'd0);
        repeat (3) @(negedge clk);
        check("nom_glob_hold", 48'({filterSize, numLayers, filterOffset, denseOffset}),
              48'h01_03_000E_0032);

        // Consumer stalls layer 1 for five cycles
        run_parse(1, 5, 0);
        check("stall_stable", 48'(stable_ok), 48'd1);
        check("stall_ndesc",  48'(desc_log.size()), 48'd3);
        check("stall_desc0",  log_at(0), E0);
        check("stall_desc1",  log_at(1), E1);
        check("stall_desc2",  log_at(2), E2);
        check("stall_done",   48'(done_cyc), 48'd41);
        check("stall_err",    48'(err_at_done), 48'd0);
        @(negedge clk);

        // numLayers = 0
        load_hdr(8'd1, 8'd0, 16'd14, 16'd50);
        run_parse(-1, 0, 0);
        check("nl0_ndesc", 48'(desc_log.size()), 48'd0);
        check("nl0_done",  48'(done_cyc), 48'd14);
        check("nl0_err",   48'(err_at_done), 48'd1);
        @(negedge clk);

        // numLayers = 11
        load_hdr(8'd1, 8'd11, 16'd14, 16'd50);
        run_parse(-1, 0, 0);
        check("nl11_ndesc", 48'(desc_log.size()), 48'd0);
        check("nl11_done",  48'(done_cyc), 48'd14);
        check("nl11_err",   48'(err_at_done), 48'd1);
        @(negedge clk);

        // Stored dense offset one short of the computed 50
        load_nominal(16'd49);
        run_parse(-1, 0, 0);
        check("dm_ndesc", 48'(desc_log.size()), 48'd3);
        check("dm_desc2", log_at(2), E2);
        check("dm_done",  48'(done_cyc), 48'd36);
        check("dm_err",   48'(err_at_done), 48'd2);
        @(negedge clk);
        check("dm_err_hold", 48'(err), 48'd2);

        // 0xFF00 + 255*(1+255*255) overflows 16 bits in layer 0
        load_hdr(8'd255, 8'd1, 16'hFF00, 16'd0);
        mem[6] = 8'd255;
        mem[7] = 8'd0;
        run_parse(-1, 0, 0);
        check("ovf_first_v", 48'(first_valid), 48'hFFFF_FFFF_FFFF);
        check("ovf_done",    48'(done_cyc), 48'd19);
        check("ovf_err",     48'(err_at_done), 48'd3);
        @(negedge clk);

        // Reset during F_TYPE of layer 1, then a clean full parse
        load_nominal(16'd50);
        run_parse(-1, 0, 24);
        @(negedge clk);
        check("mrst_read",   48'({readSignal, ramAddress}), 48'd0);
        check("mrst_status", 48'({desc_valid, busy, done, err}), 48'd0);
        check("mrst_glob",   48'({filterSize, numLayers, filterOffset, denseOffset}), 48'd0);
        check("mrst_state",  48'(dbg_state), 48'd0);
        RST = 1'b1;
        @(negedge clk);
        run_parse(-1, 0, 0);
        check("mrst_ndesc", 48'(desc_log.size()), 48'd3);
        check("mrst_desc0", log_at(0), E0);
        check("mrst_desc1", log_at(1), E1);
        check("mrst_desc2", log_at(2), E2);
        check("mrst_done",  48'(done_cyc), 48'd36);
        check("mrst_err",   48'(err_at_done), 48'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnn_header_reader.md
# cnn_header_reader

Reads the CNN parameter header that the load sequence writes into the shared byte RAM and presents it to the CNN engine as global fields plus a stream of per-layer descriptors. It sits between the RAM read port and the layer scheduler. It checks header consistency by recomputing the dense-section offset from the per-layer filter data and comparing it with the stored value.

## Interface
- MAX_LAYERS, 10, largest accepted layer count.
- HDR_BASE, 16'd0, RAM address of header byte 0.
- clk  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a header parse.
- ramAddress  out  16  RAM read address.
- readSignal  out  1  RAM read strobe.
- ramDataOut  in  8  RAM read data, valid the cycle after readSignal.
- filterSize  out  8  header byte 0.
- numLayers  out  8  header byte 1.
- filterOffset  out  16  header bytes 2 (MSB) and 3 (LSB).
- denseOffset  out  16  header bytes 4 (MSB) and 5 (LSB).
- desc_valid  out  1  descriptor outputs valid.
- desc_ready  in  1  consumer accepts the descriptor.
- layerIdx  out  8  layer number, 0-based.
- layerFilters  out  8  filter count of the layer.
- layerType  out  8  filter type of the layer.
- layerDense  out  8  dense count of the layer; 0 for the last layer.
- layerBase  out  16  RAM address of the layer's filter and bias block.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of parse.
- err  out  2  0 ok, 1 bad layer count, 2 dense offset mismatch, 3 address overflow; held until the next start.

## Operation
- RAM layout, with L = numLayers:
  - bytes 0–5: filterSize, numLayers, filterOffset, denseOffset.
  - filter counts at 6..5+L.
  - filter types at 6+L..5+2L.
  - dense counts at 6+2L..4+3L.
- All addresses are relative to HDR_BASE.
- States: IDLE, HDR, CHECK, F_CNT, F_TYPE, F_DENSE, CALC, PRESENT, FINAL.
- IDLE: start=1 → HDR, busy=1, err cleared, layer index cleared. start is ignored in every other state.
- HDR: reads bytes 0..5 in order and latches them into the global outputs.
- CHECK:
  - numLayers==0 or numLayers>MAX_LAYERS → err=1, go to FINAL.
  - otherwise set running base = filterOffset and go to F_CNT.
- F_CNT → F_TYPE → F_DENSE: read the layer's three bytes at 6+i, 6+L+i and 6+2L+i.
  - For the last layer (i==L-1), F_DENSE is skipped and layerDense=0.
- CALC:
  - layerBase = running base.
  - increment = n·(1+fs·fs), n=layerFilters, fs=filterSize, computed at 24 bits.
  - new base = base + increment, computed at 25 bits.
  - If bits 24:16 of the new base are nonzero → err=3, go to FINAL without presenting the layer.
  - Otherwise store the low 16 bits as the running base and go to PRESENT.
- PRESENT:
  - desc_valid=1; all descriptor outputs stay stable while desc_valid=1 and desc_ready=0.
  - desc_ready=1 → accept: i+1; if i was L-1 go to FINAL, else go to F_CNT.
- FINAL:
  - If err==0 and running base ≠ denseOffset → err=2.
  - done=1 for one cycle, busy=0, go to IDLE.
- Global outputs keep their values after done until the next parse overwrites them.

## Timing
- Byte read takes 2 cycles:
  - issue cycle: readSignal=1, ramAddress set.
  - capture cycle: readSignal=0, data latched from ramDataOut.
- HDR = 12 cycles. CHECK = 1. Per layer: 6 fetch cycles (4 for the last layer) + 1 CALC cycle + ≥1 PRESENT cycle.
- With desc_ready tied high, the first desc_valid appears 21 cycles after the start-accept edge.
- done is asserted on the cycle after the last accept, or after CHECK/CALC on an error.
- Reset values: all outputs 0, state IDLE.
- RST=0 mid-parse: at the next edge the block is in IDLE with readSignal=0, desc_valid=0, done=0, err=0, and the global fields are zeroed.
- ramAddress is 0 whenever readSignal=0.

## Test plan
- Nominal header (fs=1, L=3, filterOffset=14, counts 6/6/6, types 0/1/1, dense 12/12, denseOffset=50) → descriptors (0,6,0,12,14), (1,6,1,12,26), (2,6,1,0,38), then done with err=0.
- Same header, desc_ready low for 5 cycles on layer 1 → outputs held stable; three descriptors total with no duplicates.
- numLayers=0, and separately numLayers=11 → no desc_valid; done with err=1 at cycle 14 after start.
- denseOffset=49 with the nominal header → all three descriptors delivered, then err=2.
- fs=255, count=255, filterOffset=0xFF00 → err=3 in CALC of layer 0; no descriptor.
- RST low during F_TYPE of layer 1, then start again → clean restart; full nominal sequence and err=0.
